// File: rtl/reset_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | reset_sequencer_pkg                                                  |
// | State encodings and width helpers shared by the reset sequencer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ps/1ps

package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

    // Counter must hold the larger of the hold and gap terminal counts.
    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int max_cycles;
        max_cycles = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
    endfunction

    function automatic int idx_width(input int num_domains);
        return (num_domains < 2) ? 1 : $clog2(num_domains);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_synchronizer.sv
// +----------------------------------------------------------------------+
// | reset_synchronizer                                                   |
// | Async-assert / sync-release shift chain for an active-low reset.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ps/1ps

module reset_synchronizer #(
    parameter int STAGE_COUNT = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_out
);

    logic [STAGE_COUNT-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGE_COUNT-2:0], 1'b1};
        end
    end

    assign sync_out = chain[STAGE_COUNT-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// +----------------------------------------------------------------------+
// | reset_sequencer                                                      |
// | Synchronizes the board reset and releases NUM_DOMAINS resets in      |
// | order. Define RESET_SEQ_SW_RST_EN to add the sw_rst_req restart.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ps/1ps

module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int STAGE_COUNT = 2,
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef RESET_SEQ_SW_RST_EN
    input  logic                   sw_rst_req,
`endif
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   seq_done
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IDX_W = idx_width(NUM_DOMAINS);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic sync_rel;
    logic restart;

    seq_state_e             state;
    seq_state_e             state_d;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_d;
    logic [IDX_W-1:0]       rel_idx;
    logic                   rel_fire;
    logic [NUM_DOMAINS-1:0] domain_reset_d;
    logic                   seq_done_d;

    reset_synchronizer #(
        .STAGE_COUNT (STAGE_COUNT)
    ) u_sync (
        .clk      (clk),
        .rst_n    (reset),
        .sync_out (sync_rel)
    );

`ifdef RESET_SEQ_SW_RST_EN
    // A request is meaningless until the board reset has been synchronized.
    assign restart = sw_rst_req & sync_rel;
`else
    assign restart = 1'b0;
`endif

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ASSERT;
            cnt          <= '0;
            idx          <= '0;
            domain_reset <= '0;
            seq_done     <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            idx          <= idx_d;
            domain_reset <= domain_reset_d;
            seq_done     <= seq_done_d;
        end
    end

    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        idx_d          = idx;
        domain_reset_d = domain_reset;
        seq_done_d     = seq_done;
        rel_fire       = 1'b0;
        rel_idx        = '0;

        if (restart) begin
            state_d        = ASSERT;
            cnt_d          = '0;
            idx_d          = '0;
            domain_reset_d = '0;
            seq_done_d     = 1'b0;
        end else begin
            case (state)
                ASSERT: begin
                    if (sync_rel) begin
                        if (HOLD_CYCLES == 0) begin
                            rel_fire = 1'b1;
                        end else begin
                            state_d = HOLD;
                            cnt_d   = '0;
                        end
                    end
                end
                HOLD: begin
                    if (cnt >= HOLD_LAST) begin
                        rel_fire = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                RELEASE: begin
                    if (cnt >= GAP_LAST) begin
                        rel_fire = 1'b1;
                        rel_idx  = idx + IDX_ONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase

            // Domains release lowest first, so the next release is a thermometer fill.
            if (rel_fire) begin
                domain_reset_d = NUM_DOMAINS'({domain_reset, 1'b1});
                cnt_d          = '0;
                idx_d          = rel_idx;
                if (rel_idx == LAST_IDX) begin
                    state_d    = DONE;
                    seq_done_d = 1'b1;
                end else begin
                    state_d    = RELEASE;
                end
            end
        end
    end

endmodule

`default_nettype wire
